// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg
//   Shared definitions for the two-requester I2C master arbiter:
//   - arb_state_t            : arbiter FSM encoding (IDLE, LAUNCH, XFER, CLOSE)
//   - TIMEOUT_CYCLES_DEFAULT : default watchdog budget in clocks
//   - eff_len()              : byte count with 0 mapped to 1
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_XFER   = 2'd2,
      ST_CLOSE  = 2'd3
   } arb_state_t;

   localparam int TIMEOUT_CYCLES_DEFAULT = 200;

   // A requested length of zero still moves one byte.
   function automatic logic [3:0] eff_len(input logic [3:0] len);
      return (len == 4'd0) ? 4'd1 : len;
   endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter
//   Two-way round-robin pick with a one-bit priority pointer.
//   Ports:
//     clock, reset_n : system clock, asynchronous active-low reset
//     i_req[1:0]     : request vector
//     i_take         : the pick is being accepted this clock
//     o_pick         : index of the chosen requester (valid when i_req != 0)
//   The pointer names the requester that wins a tie. After reset it is 0;
//   after each accepted pick it moves to the requester not just granted.
module i2c_rr_arbiter (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_pick
);

   logic r_prio;

   always_comb begin
      o_pick = r_prio;
      if (i_req == 2'b01) begin
         o_pick = 1'b0;
      end else if (i_req == 2'b10) begin
         o_pick = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prio <= 1'b0;
      end else if (i_take) begin
         r_prio <= ~o_pick;
      end
   end

endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Shares one I2C master controller between two requesters.
//   Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a transaction when
//   the master makes no progress for TIMEOUT_CYCLES clocks. Without the macro
//   the arbiter waits indefinitely and no counter exists.
//   Ports:
//     clock, reset_n              : system clock, asynchronous active-low reset
//     req[1:0]                    : level request per requester
//     reqN_addr/mode/len/wdata    : per-requester transaction description
//     gnt[1:0]                    : one-hot grant, held for the transaction
//     nxt/rvld/done/err[1:0]      : one-clock pulses to the granted requester
//     rdata[7:0]                  : read byte, qualified by rvld
//     m_en/m_start/m_stop/m_mode  : master controls
//     m_address/m_registor        : master address and write byte
//     m_data_out/m_idle/m_byte_done/m_nack : master status
//     o_dbg_state[1:0]            : current FSM state
//   Handshake: nxt, rvld, done and err are single-clock strobes with no
//   back-pressure; a requester must present its next write byte on reqN_wdata
//   before the following m_byte_done and must accept rdata in the rvld clock.
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic [6:0] req0_addr,
   input  logic       req0_mode,
   input  logic [3:0] req0_len,
   input  logic [7:0] req0_wdata,
   input  logic [6:0] req1_addr,
   input  logic       req1_mode,
   input  logic [3:0] req1_len,
   input  logic [7:0] req1_wdata,
   output logic [1:0] gnt,
   output logic [1:0] nxt,
   output logic [1:0] rvld,
   output logic [1:0] done,
   output logic [1:0] err,
   output logic [7:0] rdata,
   output logic       m_en,
   output logic       m_start,
   output logic       m_stop,
   output logic       m_mode,
   output logic [6:0] m_address,
   output logic [7:0] m_registor,
   input  logic [7:0] m_data_out,
   input  logic       m_idle,
   input  logic       m_byte_done,
   input  logic       m_nack,
   output logic [1:0] o_dbg_state
);

   arb_state_t r_state, w_next;
   logic       r_g;          // index of the granted requester
   logic [1:0] r_gnt;
   logic [6:0] r_addr;
   logic       r_mode;
   logic [3:0] r_cnt;        // bytes still to move
   logic       r_err_seen;   // suppresses done after an error
   logic       w_pick;
   logic       w_take;
   logic       w_dec;
   logic       w_abort;

   i2c_rr_arbiter u_rr (
      .clock   (clock),
      .reset_n (reset_n),
      .i_req   (req),
      .i_take  (w_take),
      .o_pick  (w_pick)
   );

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [WDOG_W-1:0] r_wdog;

   // Any state change or byte completion counts as progress.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wdog <= '0;
      end else if (r_state == ST_IDLE || w_next != r_state || m_byte_done) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   assign w_abort = (r_state != ST_IDLE) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES));
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
   assign w_abort      = 1'b0;
`endif

   always_comb begin
      w_next  = r_state;
      w_take  = 1'b0;
      w_dec   = 1'b0;
      nxt     = 2'b00;
      rvld    = 2'b00;
      done    = 2'b00;
      err     = 2'b00;
      rdata   = 8'h00;
      m_start = 1'b0;
      m_stop  = 1'b0;
      m_en    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (req != 2'b00 && m_idle) begin
               w_take = 1'b1;
               w_next = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            m_start = 1'b1;
            m_stop  = (r_cnt == 4'd1);
            if (!m_idle) begin
               w_next = ST_XFER;
            end
         end
         ST_XFER: begin
            m_start = 1'b1;
            m_stop  = (r_cnt == 4'd1);
            if (m_nack) begin
               err[r_g] = 1'b1;
               w_next   = ST_CLOSE;
            end else if (m_byte_done) begin
               w_dec = 1'b1;
               if (r_mode) begin
                  rvld[r_g] = 1'b1;
                  rdata     = m_data_out;
               end else begin
                  nxt[r_g] = 1'b1;
               end
               if (r_cnt == 4'd1) begin
                  w_next = ST_CLOSE;
               end
            end
         end
         ST_CLOSE: begin
            m_stop = 1'b1;
            if (m_idle) begin
               if (!r_err_seen) begin
                  done[r_g] = 1'b1;
               end
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      // Watchdog abort overrides whatever the state would otherwise do.
      if (w_abort) begin
         w_dec    = 1'b0;
         nxt      = 2'b00;
         rvld     = 2'b00;
         done     = 2'b00;
         rdata    = 8'h00;
         err      = 2'b00;
         err[r_g] = 1'b1;
         m_en     = 1'b0;
         w_next   = ST_IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_g        <= 1'b0;
         r_gnt      <= 2'b00;
         r_addr     <= 7'd0;
         r_mode     <= 1'b0;
         r_cnt      <= 4'd0;
         r_err_seen <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_g        <= w_pick;
            r_gnt      <= w_pick ? 2'b10 : 2'b01;
            r_addr     <= w_pick ? req1_addr : req0_addr;
            r_mode     <= w_pick ? req1_mode : req0_mode;
            r_cnt      <= eff_len(w_pick ? req1_len : req0_len);
            r_err_seen <= 1'b0;
         end else begin
            if (w_next == ST_IDLE) begin
               r_gnt <= 2'b00;
            end
            if (w_dec) begin
               r_cnt <= r_cnt - 4'd1;
            end
            if (err != 2'b00) begin
               r_err_seen <= 1'b1;
            end
         end
      end
   end

   assign gnt         = r_gnt;
   assign m_address   = r_addr;
   assign m_mode      = r_mode;
   assign m_registor  = r_gnt[1] ? req1_wdata : (r_gnt[0] ? req0_wdata : 8'h00);
   assign o_dbg_state = r_state;

endmodule
